// File: rtl/slave_in_port.sv
// Slave-side serial bus receiver: claims transactions addressed to SLAVE_ID,
// deserialises header and write data into memory strobes, or issues a read request.
module slave_in_port #(
  parameter int SLAVE_LEN   = 2,
  parameter int ADDR_LEN    = 12,
  parameter int DATA_LEN    = 8,
  parameter int BURST_LEN   = 12,
  parameter int SLAVE_ID    = 0,
  parameter int CMD_TIMEOUT = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_slave_select,
  input  logic                 write_en,
  input  logic                 read_en,
  input  logic                 rx_address,
  input  logic                 rx_burst_number,
  input  logic                 rx_data,
  input  logic                 master_valid,
  output logic                 slave_ready,
  output logic                 mem_wr_en,
  output logic [ADDR_LEN-1:0]  mem_addr,
  output logic [DATA_LEN-1:0]  mem_wdata,
  output logic                 read_req,
  output logic [ADDR_LEN-1:0]  read_addr,
  output logic [BURST_LEN-1:0] read_burst,
  output logic                 write_done,
  output logic                 rx_error
);
  // state     | meaning
  // IDLE      | waiting for a start bit on the select line
  // SELECT    | shifting in the slave ID
  // WAIT_CMD  | claimed, waiting for write_en/read_en (timed out by tmr)
  // RX_HEADER | shifting in address and burst count
  // RX_DATA   | shifting in write words, one memory strobe per word
  // READ_REQ  | one-cycle read request to the read-return path
  typedef enum logic [2:0] {IDLE, SELECT, WAIT_CMD, RX_HEADER, RX_DATA, READ_REQ} state_t;

  localparam int H    = (ADDR_LEN > BURST_LEN) ? ADDR_LEN : BURST_LEN;
  localparam int M1   = (H > DATA_LEN) ? H : DATA_LEN;
  localparam int MAXL = (M1 > SLAVE_LEN) ? M1 : SLAVE_LEN;
  localparam int CW   = $clog2(MAXL + 1);
  localparam int TW   = $clog2(CMD_TIMEOUT + 1);

  localparam logic [CW-1:0]        SEL_LAST   = CW'(SLAVE_LEN - 1);
  localparam logic [CW-1:0]        HDR_LAST   = CW'(H - 1);
  localparam logic [CW-1:0]        DATA_LAST  = CW'(DATA_LEN - 1);
  localparam logic [CW-1:0]        ADDR_BITS  = CW'(ADDR_LEN);
  localparam logic [CW-1:0]        BURST_BITS = CW'(BURST_LEN);
  localparam logic [TW-1:0]        TMO_LOAD   = TW'(CMD_TIMEOUT - 1);
  localparam logic [SLAVE_LEN-1:0] MY_ID      = SLAVE_LEN'(SLAVE_ID);

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [TW-1:0]        tmr;
  logic                 is_write;
  logic [SLAVE_LEN-1:0] id_sr, id_next;
  logic [ADDR_LEN-1:0]  addr_sr, addr_fin, cur_addr;
  logic [BURST_LEN-1:0] burst_sr, burst_fin, words_left;
  logic [DATA_LEN-1:0]  word_sr, word_next;
  logic                 cmd_active;

  // Shift registers fill from the top so the first (LSB) bit ends in bit 0.
  always_comb begin
    id_next    = {rx_slave_select, id_sr[SLAVE_LEN-1:1]};
    word_next  = {rx_data, word_sr[DATA_LEN-1:1]};
    addr_fin   = addr_sr;
    burst_fin  = burst_sr;
    if (cnt < ADDR_BITS)  addr_fin  = {rx_address, addr_sr[ADDR_LEN-1:1]};
    if (cnt < BURST_BITS) burst_fin = {rx_burst_number, burst_sr[BURST_LEN-1:1]};
    cmd_active = is_write ? write_en : read_en;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      tmr         <= '0;
      is_write    <= 1'b0;
      id_sr       <= '0;
      addr_sr     <= '0;
      burst_sr    <= '0;
      word_sr     <= '0;
      cur_addr    <= '0;
      words_left  <= '0;
      slave_ready <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      read_req    <= 1'b0;
      read_addr   <= '0;
      read_burst  <= '0;
      write_done  <= 1'b0;
      rx_error    <= 1'b0;
    end else begin
      mem_wr_en  <= 1'b0;
      read_req   <= 1'b0;
      write_done <= 1'b0;
      rx_error   <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (rx_slave_select) state <= SELECT;
        end
        SELECT: begin
          id_sr <= id_next;
          if (cnt == SEL_LAST) begin
            cnt <= '0;
            if (id_next == MY_ID) begin
              state       <= WAIT_CMD;
              slave_ready <= 1'b1;
              tmr         <= TMO_LOAD;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_CMD: begin
          cnt <= '0;
          if (write_en || read_en) begin
            is_write <= write_en;
            state    <= RX_HEADER;
          end else if (tmr == '0) begin
            rx_error    <= 1'b1;
            slave_ready <= 1'b0;
            state       <= IDLE;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        RX_HEADER: begin
          if (!cmd_active) begin
            rx_error    <= 1'b1;
            slave_ready <= 1'b0;
            state       <= IDLE;
          end else begin
            addr_sr  <= addr_fin;
            burst_sr <= burst_fin;
            if (cnt == HDR_LAST) begin
              cnt        <= '0;
              cur_addr   <= addr_fin;
              words_left <= (burst_fin == '0) ? '0 : burst_fin - BURST_LEN'(1);
              if (is_write) begin
                state <= RX_DATA;
              end else begin
                state      <= READ_REQ;
                read_req   <= 1'b1;
                read_addr  <= addr_fin;
                read_burst <= (burst_fin == '0) ? BURST_LEN'(1) : burst_fin;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        RX_DATA: begin
          if (!write_en) begin
            rx_error    <= 1'b1;
            slave_ready <= 1'b0;
            state       <= IDLE;
          end else if (master_valid) begin
            word_sr <= word_next;
            if (cnt == DATA_LAST) begin
              cnt       <= '0;
              mem_wr_en <= 1'b1;
              mem_addr  <= cur_addr;
              mem_wdata <= word_next;
              cur_addr  <= cur_addr + ADDR_LEN'(1);
              if (words_left == '0) begin
                write_done  <= 1'b1;
                slave_ready <= 1'b0;
                state       <= IDLE;
              end else begin
                words_left <= words_left - BURST_LEN'(1);
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        READ_REQ: begin
          slave_ready <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          slave_ready <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_slave_in_port.sv
// Directed bench for slave_in_port: write, burst/wrap, read, ID mismatch,
// timeout, abort and mid-burst reset with hand-computed expectations.
module tb_slave_in_port;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_slave_select = 1'b0, write_en = 1'b0, read_en = 1'b0;
  logic        rx_address = 1'b0, rx_burst_number = 1'b0, rx_data = 1'b0, master_valid = 1'b0;
  logic        slave_ready, mem_wr_en, read_req, write_done, rx_error;
  logic [11:0] mem_addr, read_addr, read_burst;
  logic [7:0]  mem_wdata;

  int n_chk = 0, n_pass = 0;
  int n_wr = 0, n_done = 0, n_err = 0, n_rreq = 0;
  logic [11:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  logic        wr_done_q[$];

  slave_in_port dut (
    .clk(clk), .reset(reset), .rx_slave_select(rx_slave_select),
    .write_en(write_en), .read_en(read_en), .rx_address(rx_address),
    .rx_burst_number(rx_burst_number), .rx_data(rx_data), .master_valid(master_valid),
    .slave_ready(slave_ready), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .read_req(read_req), .read_addr(read_addr),
    .read_burst(read_burst), .write_done(write_done), .rx_error(rx_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_wr_en) begin
      n_wr++;
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
      wr_done_q.push_back(write_done);
    end
    if (write_done) n_done++;
    if (rx_error)   n_err++;
    if (read_req)   n_rreq++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic select_id(input logic [1:0] id);
    rx_slave_select = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      rx_slave_select = id[i];
      step();
    end
    rx_slave_select = 1'b0;
  endtask

  // Command cycle followed by the 12 header cycles; command left asserted.
  task automatic header(input logic [11:0] addr, input logic [11:0] burst, input logic wr);
    write_en = wr;
    read_en  = ~wr;
    step();
    for (int i = 0; i < 12; i++) begin
      rx_address      = addr[i];
      rx_burst_number = burst[i];
      step();
    end
    rx_address      = 1'b0;
    rx_burst_number = 1'b0;
  endtask

  // Bits LSB first; two idle cycles inserted before bit gap_pos (8 = no gap).
  task automatic send_word(input logic [7:0] data, input int gap_pos);
    for (int i = 0; i < 8; i++) begin
      if (i == gap_pos) begin
        master_valid = 1'b0;
        rx_data      = 1'b1;
        step();
        step();
      end
      master_valid = 1'b1;
      rx_data      = data[i];
      step();
    end
    master_valid = 1'b0;
    rx_data      = 1'b0;
  endtask

  initial begin
    int wr0, done0, err0, rreq0;

    // reset state
    step();
    step();
    reset = 1'b0;
    chk("rst_slave_ready", slave_ready, 0);
    chk("rst_pulses", {mem_wr_en, read_req, write_done, rx_error}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    step();

    // single write
    select_id(2'd0);
    chk("sw_ready", slave_ready, 1);
    header(12'h123, 12'd0, 1'b1);
    send_word(8'hA5, 8);
    chk("sw_wr_en", mem_wr_en, 1);
    chk("sw_addr", mem_addr, 12'h123);
    chk("sw_data", mem_wdata, 8'hA5);
    chk("sw_done", write_done, 1);
    write_en = 1'b0;
    step();
    chk("sw_ready_after", slave_ready, 0);
    chk("sw_wr_count", n_wr, 1);

    // burst write with gap and address wrap
    wr0 = n_wr; done0 = n_done;
    select_id(2'd0);
    header(12'hFFE, 12'd3, 1'b1);
    send_word(8'h11, 8);
    send_word(8'h22, 3);
    send_word(8'h33, 8);
    write_en = 1'b0;
    step();
    chk("bw_count", n_wr - wr0, 3);
    chk("bw_done_count", n_done - done0, 1);
    if (n_wr - wr0 == 3) begin
      chk("bw_a0", wr_addr_q[wr0],     12'hFFE);
      chk("bw_d0", wr_data_q[wr0],     8'h11);
      chk("bw_a1", wr_addr_q[wr0 + 1], 12'hFFF);
      chk("bw_d1", wr_data_q[wr0 + 1], 8'h22);
      chk("bw_a2", wr_addr_q[wr0 + 2], 12'h000);
      chk("bw_d2", wr_data_q[wr0 + 2], 8'h33);
      chk("bw_done_flags", {wr_done_q[wr0], wr_done_q[wr0 + 1], wr_done_q[wr0 + 2]}, 3'b001);
    end

    // read request, visible exactly H+1 cycles after the command cycle
    wr0 = n_wr; rreq0 = n_rreq;
    select_id(2'd0);
    header(12'h040, 12'd5, 1'b0);
    chk("rd_req", read_req, 1);
    chk("rd_addr", read_addr, 12'h040);
    chk("rd_burst", read_burst, 12'd5);
    chk("rd_ready", slave_ready, 1);
    read_en = 1'b0;
    step();
    chk("rd_req_off", read_req, 0);
    chk("rd_ready_off", slave_ready, 0);
    chk("rd_req_count", n_rreq - rreq0, 1);
    chk("rd_no_writes", n_wr - wr0, 0);

    // ID mismatch: traffic ignored, then ID 0 accepted and left to time out
    wr0 = n_wr; err0 = n_err;
    select_id(2'd2);
    chk("idm_ready", slave_ready, 0);
    write_en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      rx_address   = i[0];
      master_valid = 1'b1;
      rx_data      = i[1];
      step();
    end
    write_en = 1'b0; master_valid = 1'b0; rx_address = 1'b0; rx_data = 1'b0;
    chk("idm_ready_hold", slave_ready, 0);
    chk("idm_no_writes", n_wr - wr0, 0);
    select_id(2'd0);
    chk("to_ready", slave_ready, 1);
    repeat (9) step();
    chk("to_not_yet", {rx_error, slave_ready}, 2'b01);
    step();
    chk("to_error", {rx_error, slave_ready}, 2'b10);
    step();
    chk("to_error_pulse", rx_error, 0);
    chk("to_err_count", n_err - err0, 1);

    // abort mid-word 2
    wr0 = n_wr; done0 = n_done; err0 = n_err;
    select_id(2'd0);
    header(12'h200, 12'd2, 1'b1);
    send_word(8'h5A, 8);
    for (int i = 0; i < 4; i++) begin
      master_valid = 1'b1;
      rx_data      = i[0];
      step();
    end
    write_en = 1'b0;
    rx_data  = 1'b1;
    step();
    chk("ab_error", rx_error, 1);
    chk("ab_ready", slave_ready, 0);
    repeat (6) step();
    master_valid = 1'b0;
    step();
    chk("ab_wr_count", n_wr - wr0, 1);
    chk("ab_done_count", n_done - done0, 0);
    chk("ab_err_count", n_err - err0, 1);
    if (n_wr - wr0 >= 1) begin
      chk("ab_addr", wr_addr_q[wr0], 12'h200);
      chk("ab_data", wr_data_q[wr0], 8'h5A);
    end

    // reset on the cycle that would complete a word
    wr0 = n_wr;
    select_id(2'd0);
    header(12'h300, 12'd2, 1'b1);
    for (int i = 0; i < 7; i++) begin
      master_valid = 1'b1;
      rx_data      = 1'b1;
      step();
    end
    reset = 1'b1;
    step();
    chk("rs_outputs", {slave_ready, mem_wr_en, read_req, write_done, rx_error}, 0);
    chk("rs_mem_addr", mem_addr, 0);
    reset = 1'b0;
    repeat (10) step();
    write_en = 1'b0; master_valid = 1'b0; rx_data = 1'b0;
    step();
    chk("rs_no_writes", n_wr - wr0, 0);
    select_id(2'd0);
    header(12'h7FF, 12'd0, 1'b1);
    send_word(8'h3C, 8);
    chk("rs_fresh", {mem_wr_en, write_done}, 2'b11);
    chk("rs_fresh_addr", mem_addr, 12'h7FF);
    chk("rs_fresh_data", mem_wdata, 8'h3C);
    write_en = 1'b0;
    step();
    chk("rs_fresh_count", n_wr - wr0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
